serial_ripple_borrow_subtractor: RTL and testbench
==================================================

Name: serial_ripple_borrow_subtractor

Overview:
- Bit-serial subtractor: computes result = A - B - borrowin over NUMBITS clock cycles.
- One full-subtractor cell with a registered borrow, one bit per clock, LSB first.
- Sequential inverse of the team's combinational ripple-carry adder. Used where area matters more than latency.
- start/busy/done handshake. Result and flags stay held until the next accepted start.

Parameters:
- NUMBITS, 16, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled on the rising edge; accepted only when busy=0
- A  input  NUMBITS  minuend; captured on the accepting edge
- B  input  NUMBITS  subtrahend; captured on the accepting edge
- borrowin  input  1  initial borrow; captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result and flags are valid from this cycle on
- result  output  NUMBITS  (A - B - borrowin) mod 2^NUMBITS
- borrowout  output  1  1 iff unsigned A < B + borrowin
- overflow  output  1  signed two's-complement overflow of the subtraction

Behaviour:
- Reset is synchronous and active-high. While rst=1 at a rising edge:
  - state goes to IDLE; busy=0, done=0, result=0, borrowout=0, overflow=0.
  - internal operand registers, bit counter and borrow register are cleared.
  - rst overrides start and any in-flight operation.
- States:
  - IDLE: start=1 -> capture A, B, borrowin; counter=0; go to RUN. Otherwise stay.
  - RUN: busy=1. Each edge processes bit i=counter:
    - d_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br)
    - d_i is written into result bit i; counter increments.
    - On the edge that processes bit NUMBITS-1, go to DONE. On that same edge: borrowout = final br_next; overflow = (a_msb ^ b_msb) & (a_msb ^ d_msb).
  - DONE: done=1 and busy=0 for exactly one cycle. Next edge: start=1 -> capture new operands and go to RUN (back-to-back); otherwise go to IDLE.
- Latency: start is sampled at edge E0. Bits are computed on edges E1..E_NUMBITS. done is high during the cycle after E_NUMBITS. Throughput is one op per NUMBITS+1 cycles when start is held.
- start while busy=1 is ignored. In-flight operands are unaffected, and the ignored request is not queued.
- A, B and borrowin may change freely after the accepting edge. Only the captured copies are used.
- result updates bit-by-bit during RUN and is meaningful only when done=1 or later.
- result, borrowout and overflow hold their DONE values through IDLE until the next accepted start. On that start they may be overwritten progressively.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan (NUMBITS=16):
- A=0x0005, B=0x0003, borrowin=0, pulse start -> done exactly 17 cycles after the start cycle; result=0x0002, borrowout=0, overflow=0; busy high for 16 cycles.
- A=0x0000, B=0x0001, borrowin=0 -> result=0xFFFF, borrowout=1, overflow=0. Then A=0x1234, B=0x1234, borrowin=1 -> result=0xFFFF, borrowout=1.
- A=0x8000, B=0x0001 -> result=0x7FFF, borrowout=0, overflow=1. A=0x7FFF, B=0xFFFF -> result=0x8000, borrowout=1, overflow=1.
- Start op A=0x00FF, B=0x0001; pulse start with A=0xAAAA on cycle 5 of RUN -> ignored; result=0x00FE; no second done pulse.
- Assert rst on cycle 8 of RUN -> next cycle busy=0, done=0, result=0, borrowout=0, overflow=0. A following start of 0x0010-0x0001 yields 0x000F normally.
- Hold start=1 across DONE with new operands 0x0003-0x0004 -> RUN resumes the cycle after done with no IDLE gap; second done gives result=0xFFFF, borrowout=1.

Source files
------------

// File: rtl/serial_ripple_borrow_subtractor.sv
// Bit-serial subtractor: result = A - B - borrowin, one bit per clock, LSB first.
// A single full-subtractor cell with a registered borrow walks across the
// captured operands. Result and flags are held after completion until the
// next accepted start.
module serial_ripple_borrow_subtractor #(
    parameter int NUMBITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic               borrowin,
    output logic               busy,
    output logic               done,
    output logic [NUMBITS-1:0] result,
    output logic               borrowout,
    output logic               overflow
);

    localparam int CW = (NUMBITS > 1) ? $clog2(NUMBITS) : 1;
    localparam logic [CW-1:0] LASTBIT = CW'(NUMBITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUMBITS-1:0] opa;
    logic [NUMBITS-1:0] opb;
    logic [CW-1:0]      cnt;
    logic               br;

    logic accept;
    logic lastbit;
    logic ai;
    logic bi;
    logic di;
    logic brnext;

    // Operands are shifted right each bit, so the current bit always sits at bit 0.
    assign ai      = opa[0];
    assign bi      = opb[0];
    assign di      = ai ^ bi ^ br;
    assign brnext  = (~ai & bi) | (~ai & br) | (bi & br);
    assign lastbit = (cnt == LASTBIT);
    assign accept  = start && (state != RUN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the state register only.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (lastbit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, then one full-subtractor step per edge in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa       <= '0;
            opb       <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            borrowout <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            opa <= A;
            opb <= B;
            br  <= borrowin;
            cnt <= '0;
        end else if (state == RUN) begin
            result[cnt] <= di;
            opa         <= opa >> 1;
            opb         <= opb >> 1;
            br          <= brnext;
            cnt         <= cnt + 1'b1;
            if (lastbit) begin
                borrowout <= brnext;
                overflow  <= (ai ^ bi) & (ai ^ di);
            end
        end
    end

endmodule

// File: tb/tb_serial_ripple_borrow_subtractor.sv
// Self-checking bench for serial_ripple_borrow_subtractor (NUMBITS=16):
// directed scenarios plus randomized operations against an arithmetic model.
module tb_serial_ripple_borrow_subtractor;

    localparam int N = 16;
    localparam int LIMIT = 60;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         borrowin;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         borrowout;
    logic         overflow;

    int checks;
    int errors;

    serial_ripple_borrow_subtractor #(.NUMBITS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .borrowin (borrowin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .borrowout(borrowout),
        .overflow (overflow)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Arithmetic reference: plain integer subtraction, unsigned and signed views.
    task automatic refModel(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                            output logic [N-1:0] r, output logic bo, output logic ov);
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        longint diff;
        ua   = longint'(a);
        ub   = longint'(b);
        diff = ua - ub - longint'(bin);
        r    = diff[N-1:0];
        bo   = (ua < ub + longint'(bin));
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        diff = sa - sb - longint'(bin);
        ov   = (diff > (2**(N-1)) - 1) || (diff < -(2**(N-1)));
    endtask

    // Issue a one-cycle start with the given operands; scramble inputs afterwards.
    task automatic pulseStart(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        @(negedge clk);
        A        = a;
        B        = b;
        borrowin = bin;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        A        = N'($urandom);
        B        = N'($urandom);
        borrowin = 1'($urandom);
    endtask

    // Step negedges until done, bounded; reports elapsed cycles and busy cycles seen.
    task automatic waitDone(output int n, output int busyn);
        n     = 0;
        busyn = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) busyn++;
        end while (!done && n < LIMIT);
    endtask

    // Full operation with latency, busy-length, result, flag and pulse-width checks.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        logic [N-1:0] er;
        logic         ebo;
        logic         eov;
        int           n;
        int           bn;
        refModel(a, b, bin, er, ebo, eov);
        pulseStart(a, b, bin);
        waitDone(n, bn);
        checkOutput("latency", 64'(n), 64'(N + 1));
        checkOutput("busycycles", 64'(bn), 64'(N));
        checkOutput("result", 64'(result), 64'(er));
        checkOutput("borrowout", 64'(borrowout), 64'(ebo));
        checkOutput("overflow", 64'(overflow), 64'(eov));
        @(negedge clk);
        checkOutput("donepulse", 64'(done), 64'd0);
        checkOutput("resulthold", 64'(result), 64'(er));
    endtask

    initial begin
        int n;
        int bn;
        int donecount;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        borrowin = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_result", 64'(result), 64'd0);
        checkOutput("rst_borrowout", 64'(borrowout), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;

        $display("[TB] directed operations");
        applyStimulus(16'h0005, 16'h0003, 1'b0);
        applyStimulus(16'h0000, 16'h0001, 1'b0);
        applyStimulus(16'h1234, 16'h1234, 1'b1);
        applyStimulus(16'h8000, 16'h0001, 1'b0);
        applyStimulus(16'h7FFF, 16'hFFFF, 1'b0);
        applyStimulus(16'h8000, 16'h7FFF, 1'b1);

        $display("[TB] start while busy is ignored");
        pulseStart(16'h00FF, 16'h0001, 1'b0);
        repeat (4) @(negedge clk);
        @(negedge clk);
        A     = 16'hAAAA;
        B     = 16'h0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(n, bn);
        checkOutput("ign_latency", 64'(n + 5), 64'(N + 1));
        checkOutput("ign_result", 64'(result), 64'h00FE);
        donecount = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            if (done) donecount++;
        end
        checkOutput("ign_no2nddone", 64'(donecount), 64'd0);

        $display("[TB] reset during run");
        pulseStart(16'hFFFF, 16'h0000, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_result", 64'(result), 64'd0);
        checkOutput("midrst_borrowout", 64'(borrowout), 64'd0);
        checkOutput("midrst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        applyStimulus(16'h0010, 16'h0001, 1'b0);

        $display("[TB] back-to-back operations");
        pulseStart(16'h0009, 16'h0004, 1'b0);
        waitDone(n, bn);
        checkOutput("b2b_first_latency", 64'(n), 64'(N + 1));
        checkOutput("b2b_first_result", 64'(result), 64'h0005);
        A        = 16'h0003;
        B        = 16'h0004;
        borrowin = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_nogap_busy", 64'(busy), 64'd1);
        waitDone(n, bn);
        checkOutput("b2b_second_latency", 64'(n), 64'(N + 1));
        checkOutput("b2b_second_result", 64'(result), 64'hFFFF);
        checkOutput("b2b_second_borrowout", 64'(borrowout), 64'd1);

        $display("[TB] randomized operations");
        for (int k = 0; k < 40; k++) begin
            applyStimulus(N'($urandom), N'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
